wave_synth_high: RTL
====================

// Module: wave_synth_high
// PURPOSE
//  Test-tone synthesizer: emits signed 16-bit audio samples (square or triangle) around a fixed
//  midline, with a programmable half-period (in samples) and peak-to-peak amplitude. It is the
//  generating end of the freq/amp measurement path: its output drives the left/right sample buses
//  that the wave analyzer consumes. New settings are taken over a valid/ready handshake and applied
//  glitch-free at a period boundary.
// PARAMETERS
//  MIDLINE  567   signed DC level that every waveform is centred on
//  HP_MIN   4096  minimum half-period; keeps amp < half-period, so at most one triangle step per sample
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous, active-high reset
//  smpl_en       in   1   one-cycle sample strobe; all waveform advance is gated by it
//  cfg_vld       in   1   config offered
//  cfg_rdy       out  1   config accepted when cfg_vld & cfg_rdy
//  cfg_half_prd  in   32  samples per half-period (clamped up to HP_MIN)
//  cfg_amp       in   12  peak-to-peak amplitude, unsigned
//  cfg_shape     in   2   shape_t: 00 OFF, 01 SQUARE, 10 TRIANGLE, 11 treated as OFF
//  lft_out       out  16  signed sample
//  rght_out      out  16  signed sample, always equal to lft_out
//  out_vld       out  1   one-cycle pulse, the cycle after smpl_en
//  busy          out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, lft_out/rght_out=MIDLINE, out_vld=0, cfg_rdy=1, busy=0, pending/active cfg=0,
//   cnt=0, err=0. Reset mid-period aborts immediately; there is no drain.
//  Levels: half=amp>>1; HI=MIDLINE+half; LO=MIDLINE-(amp-half). HI-LO==amp exactly. Use 17-bit
//   signed intermediates; results always fit in 16 bits.
//  FSM IDLE -> PH_HI -> PH_LO -> PH_HI ... cnt counts samples in a phase, 0..half_prd-1. On the
//   smpl_en with cnt==half_prd-1, switch phase and clear cnt. Entering PH_HI = period start.
//  IDLE: output MIDLINE on every strobe (out_vld still pulses). An accepted non-OFF config loads
//   directly into active, level=LO, err=0; FSM enters PH_HI that cycle. The first new-shape sample
//   is produced on the next smpl_en, not in the acceptance cycle.
//  SQUARE: PH_HI outputs HI, PH_LO outputs LO.
//  TRIANGLE: level register starts at LO. Each strobe: if err+amp >= half_prd then err<=err+amp-half_prd
//   and level+=1 (PH_HI) or level-=1 (PH_LO); otherwise err<=err+amp. Level lands exactly on HI/LO
//   and err on 0 at every phase end. Output = updated level.
//  Config while running: accepted into a pending register, then cfg_rdy=0 until applied. It is
//   applied at the PH_LO->PH_HI strobe: active<=pending, level<=new LO, err<=0. cfg_rdy returns to
//   1 the next cycle. cfg_vld is ignored while cfg_rdy=0, including the apply cycle.
//  Pending OFF: at period end go to IDLE and output MIDLINE. A config never cuts a period short.
//  cfg_half_prd < HP_MIN is stored as HP_MIN; cnt compare uses the stored value.
//  Latency: lft_out and out_vld are registered, one cycle after the smpl_en that produced them.
//  smpl_en held high: one sample per clock, which is legal.
// STRUCTURE
//  wave_pkg:
//   - shape_t enum
//   - state_t {IDLE,PH_HI,PH_LO}
//   - MIDLINE/HP_MIN defaults
//   - cfg_t struct {half_prd, amp, shape}
//  Sub-module tri_stepper: Bresenham level/err update (inputs: amp, half_prd, dir, step_en, load).
//  Top level holds the FSM, cnt, cfg handshake and output registers.
// TESTING
//  1 SQUARE amp=1000 hp=4096, smpl_en every clk -> 4096 samples of 1067, 4096 of 67, repeating;
//    out_vld one cycle after each strobe.
//  2 TRIANGLE amp=4095 hp=4096 -> starts -1481, sample 4096 = 2614, sample 8192 = -1481;
//    consecutive samples differ by 0 or 1; err==0 at each phase end.
//  3 cfg hp=100 amp=200 SQUARE -> phase length 4096 (clamped); outputs 667/467.
//  4 Mid-PH_HI new cfg amp=500 -> cfg_rdy drops; old waveform finishes PH_LO; new levels 817/317
//    from the next period start; cfg_rdy=1 a cycle later; second cfg_vld during the wait ignored.
//  5 Pending OFF -> current period completes, then busy=0 and output 567.
//  6 rst pulse mid-triangle with smpl_en active -> same cycle lft_out=567, out_vld=0, IDLE;
//    no sample on the strobe that coincides with rst.

Source files
------------

// File: rtl/wave_synth_high_pkg.sv
// wave_synth_high_pkg: shared types and helpers for the test-tone synthesizer.
//   shape_t  - waveform select (00 OFF, 01 SQUARE, 10 TRIANGLE, 11 reserved = OFF)
//   state_t  - phase FSM states
//   cfg_t    - one complete tone setting {half_prd, amp, shape}
//   lvl_hi / lvl_lo - waveform extremes around a midline; HI-LO == amp exactly
package wave_synth_high_pkg;

    localparam int MIDLINE_DEF = 567;
    localparam int HP_MIN_DEF  = 4096;

    typedef enum logic [1:0] {
        SH_OFF      = 2'b00,
        SH_SQUARE   = 2'b01,
        SH_TRIANGLE = 2'b10,
        SH_RSVD     = 2'b11
    } shape_t;

    typedef enum logic [1:0] {IDLE, PH_HI, PH_LO} state_t;

    typedef struct packed {
        logic [31:0] half_prd;
        logic [11:0] amp;
        shape_t      shape;
    } cfg_t;

    function automatic logic shape_on(input shape_t s);
        return (s == SH_SQUARE) || (s == SH_TRIANGLE);
    endfunction

    // HI = mid + amp/2 ; odd amplitudes put the extra LSB below the midline
    function automatic logic signed [15:0] lvl_hi(input logic [11:0] amp, input int mid);
        logic signed [16:0] v;
        v = 17'(mid) + $signed({6'b0, amp[11:1]});
        return v[15:0];
    endfunction

    function automatic logic signed [15:0] lvl_lo(input logic [11:0] amp, input int mid);
        logic signed [16:0] v;
        v = 17'(mid) - $signed({5'b0, amp - {1'b0, amp[11:1]}});
        return v[15:0];
    endfunction

endpackage

// File: rtl/wave_synth_high_if.sv
// wave_synth_high_if: config handshake, sample strobe and sample output bus.
//   master - the side that strobes samples and offers config (sequencer / bench)
//   slave  - the synthesizer
interface wave_synth_high_if;
    logic               smpl_en;
    logic               cfg_vld;
    logic               cfg_rdy;
    logic [31:0]        cfg_half_prd;
    logic [11:0]        cfg_amp;
    logic [1:0]         cfg_shape;
    logic signed [15:0] lft_out;
    logic signed [15:0] rght_out;
    logic               out_vld;
    logic               busy;

    modport master (
        output smpl_en, cfg_vld, cfg_half_prd, cfg_amp, cfg_shape,
        input  cfg_rdy, lft_out, rght_out, out_vld, busy
    );

    modport slave (
        input  smpl_en, cfg_vld, cfg_half_prd, cfg_amp, cfg_shape,
        output cfg_rdy, lft_out, rght_out, out_vld, busy
    );
endinterface

// File: rtl/wave_synth_high_tri_stepper.sv
// wave_synth_high_tri_stepper: Bresenham ramp generator for the triangle shape.
//   amp, half_prd - slope: amp steps of 1 spread evenly over half_prd strobes
//   dir           - 1 ramps up (PH_HI), 0 ramps down (PH_LO)
//   step_en       - advance one sample
//   load/load_lvl - restart at load_lvl with zero error (period start)
//   level_nxt     - level after this strobe's step, used as the sample value
module wave_synth_high_tri_stepper
#(
    parameter int MIDLINE = 567
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        amp,
    input  logic [31:0]        half_prd,
    input  logic               dir,
    input  logic               step_en,
    input  logic               load,
    input  logic signed [15:0] load_lvl,
    output logic signed [15:0] level_nxt
);

    logic signed [15:0] level_q;
    logic [31:0]        err_q, err_nxt;
    logic [32:0]        sum;

    // amp < half_prd is guaranteed, so at most one step per strobe
    always_comb begin
        sum       = {1'b0, err_q} + {21'b0, amp};
        err_nxt   = sum[31:0];
        level_nxt = level_q;
        if (sum >= {1'b0, half_prd}) begin
            err_nxt   = sum[31:0] - half_prd;
            level_nxt = dir ? level_q + 16'sd1 : level_q - 16'sd1;
        end
    end

    // load wins over step: the apply strobe still emits the old ramp's last sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 16'(MIDLINE);
            err_q   <= '0;
        end else if (load) begin
            level_q <= load_lvl;
            err_q   <= '0;
        end else if (step_en) begin
            level_q <= level_nxt;
            err_q   <= err_nxt;
        end
    end

endmodule

// File: rtl/wave_synth_high.sv
// wave_synth_high: square/triangle test-tone synthesizer around a fixed midline.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - wave_synth_high_if.slave: smpl_en strobe, cfg valid/ready with
//              half_prd/amp/shape, registered lft/rght samples, out_vld, busy
// New settings offered while running wait in a pending register and take
// effect only at a period start, so a period is never cut short.
module wave_synth_high
    import wave_synth_high_pkg::*;
#(
    parameter int MIDLINE = MIDLINE_DEF,
    parameter int HP_MIN  = HP_MIN_DEF
)(
    input  logic              clk,
    input  logic              rst,
    wave_synth_high_if.slave  bus
);

    state_t             state;
    logic [31:0]        cnt;
    cfg_t               act, pend, cfg_in;
    logic               pend_vld, cfg_rdy_q, busy_q, out_vld_q;
    logic signed [15:0] out_q, smp_val, lvl_nxt, ld_lvl;
    logic               accept, ph_end, start, apply, ld, step;

    always_comb begin
        cfg_in.half_prd = (bus.cfg_half_prd < 32'(HP_MIN)) ? 32'(HP_MIN) : bus.cfg_half_prd;
        cfg_in.amp      = bus.cfg_amp;
        cfg_in.shape    = shape_t'(bus.cfg_shape);
    end

    assign accept = bus.cfg_vld & cfg_rdy_q;
    assign ph_end = bus.smpl_en & (state != IDLE) & (cnt == act.half_prd - 32'd1);
    assign start  = (state == IDLE) & accept & shape_on(cfg_in.shape);
    assign apply  = ph_end & (state == PH_LO) & pend_vld;
    assign ld     = start | (apply & shape_on(pend.shape));
    assign ld_lvl = lvl_lo(start ? cfg_in.amp : pend.amp, MIDLINE);
    assign step   = bus.smpl_en & (state != IDLE) & (act.shape == SH_TRIANGLE);

    wave_synth_high_tri_stepper #(.MIDLINE(MIDLINE)) u_tri (
        .clk       (clk),
        .rst       (rst),
        .amp       (act.amp),
        .half_prd  (act.half_prd),
        .dir       (state == PH_HI),
        .step_en   (step),
        .load      (ld),
        .load_lvl  (ld_lvl),
        .level_nxt (lvl_nxt)
    );

    always_comb begin
        smp_val = 16'(MIDLINE);
        if (state != IDLE) begin
            if (act.shape == SH_TRIANGLE) smp_val = lvl_nxt;
            else if (state == PH_HI)      smp_val = lvl_hi(act.amp, MIDLINE);
            else                          smp_val = lvl_lo(act.amp, MIDLINE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            act       <= '0;
            pend      <= '0;
            pend_vld  <= 1'b0;
            cfg_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            out_q     <= 16'(MIDLINE);
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= bus.smpl_en;
            if (bus.smpl_en) out_q <= smp_val;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        act    <= cfg_in;
                        state  <= PH_HI;
                        busy_q <= 1'b1;
                    end
                end
                PH_HI, PH_LO: begin
                    if (ph_end) begin
                        cnt <= '0;
                        if (state == PH_HI) begin
                            state <= PH_LO;
                        end else if (pend_vld) begin
                            act       <= pend;
                            pend_vld  <= 1'b0;
                            cfg_rdy_q <= 1'b1;
                            state     <= shape_on(pend.shape) ? PH_HI : IDLE;
                            busy_q    <= shape_on(pend.shape);
                        end else begin
                            state <= PH_HI;
                        end
                    end else if (bus.smpl_en) begin
                        cnt <= cnt + 32'd1;
                    end
                    // cfg_rdy_q is low whenever pend_vld is set, so this never races apply
                    if (accept) begin
                        pend      <= cfg_in;
                        pend_vld  <= 1'b1;
                        cfg_rdy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.lft_out  = out_q;
    assign bus.rght_out = out_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.cfg_rdy  = cfg_rdy_q;
    assign bus.busy     = busy_q;

endmodule
